// File: rtl/entry_alloc_32.sv
// 32-entry occupancy tracker: hands out the lowest free entry, takes entries back by index,
// and flags illegal frees. Next-free index is precomputed so allocations sustain one per cycle.
module entry_alloc_32 #(
    parameter int unsigned NUM_ENTRY = 32,
    parameter logic [31:0] RSV_MASK  = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        alloc_req,
    output logic        alloc_valid,
    output logic [4:0]  alloc_idx,
    output logic        alloc_gnt,
    input  logic        free_valid,
    input  logic [4:0]  free_idx,
    input  logic        flush,
    output logic [31:0] used_map,
    output logic [5:0]  used_cnt,
    output logic        full,
    output logic        empty,
    output logic        free_err
);

    // Isolates the lowest set bit of the vector.
    function automatic logic [31:0] one_valid_32(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

    function automatic logic [4:0] encoder_32_5(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (oh[i]) idx = idx | 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] decoder_5_32(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    // Returns 0 when no zero exists; alloc_valid qualifies the index in that case.
    function automatic logic [4:0] lowest_zero(input logic [31:0] v);
        return encoder_32_5(one_valid_32(~v));
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

    logic [31:0] alloc_oh;
    logic [31:0] free_oh;
    logic        free_bad;
    logic [31:0] used_n;

    assign alloc_gnt = alloc_req & alloc_valid & ~flush;

    always_comb begin
        alloc_oh = '0;
        free_oh  = '0;
        free_bad = 1'b0;
        if (alloc_gnt) begin
            alloc_oh = decoder_5_32(alloc_idx);
        end
        // A free that races a flush is swallowed silently.
        if (free_valid && !flush) begin
            if (used_map[free_idx] && !RSV_MASK[free_idx] &&
                !(alloc_gnt && (free_idx == alloc_idx))) begin
                free_oh = decoder_5_32(free_idx);
            end else begin
                free_bad = 1'b1;
            end
        end
        if (flush) begin
            used_n = RSV_MASK;
        end else begin
            used_n = (used_map | alloc_oh) & ~free_oh;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            used_map    <= RSV_MASK;
            used_cnt    <= popcount(RSV_MASK);
            full        <= &RSV_MASK;
            empty       <= 1'b1;
            alloc_valid <= ~&RSV_MASK;
            alloc_idx   <= lowest_zero(RSV_MASK);
            free_err    <= 1'b0;
        end else begin
            used_map    <= used_n;
            used_cnt    <= popcount(used_n);
            full        <= &used_n;
            empty       <= (used_n == RSV_MASK);
            alloc_valid <= ~&used_n;
            alloc_idx   <= lowest_zero(used_n);
            free_err    <= free_err | free_bad;
        end
    end

endmodule

// File: tb/tb_entry_alloc_32.sv
// Directed bench for entry_alloc_32: one unreserved instance and one with entry 0 reserved.
module tb_entry_alloc_32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        alloc_req, free_valid, flush;
    logic [4:0]  free_idx;
    logic        alloc_valid, alloc_gnt, full, empty, free_err;
    logic [4:0]  alloc_idx;
    logic [31:0] used_map;
    logic [5:0]  used_cnt;

    logic        r_alloc_req, r_free_valid, r_flush;
    logic [4:0]  r_free_idx;
    logic        r_alloc_valid, r_alloc_gnt, r_full, r_empty, r_free_err;
    logic [4:0]  r_alloc_idx;
    logic [31:0] r_used_map;
    logic [5:0]  r_used_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    entry_alloc_32 #(.NUM_ENTRY(32), .RSV_MASK(32'h0)) dut (
        .clk(clk), .resetn(resetn), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
        .alloc_idx(alloc_idx), .alloc_gnt(alloc_gnt), .free_valid(free_valid),
        .free_idx(free_idx), .flush(flush), .used_map(used_map), .used_cnt(used_cnt),
        .full(full), .empty(empty), .free_err(free_err)
    );

    entry_alloc_32 #(.NUM_ENTRY(32), .RSV_MASK(32'h1)) dut_r (
        .clk(clk), .resetn(resetn), .alloc_req(r_alloc_req), .alloc_valid(r_alloc_valid),
        .alloc_idx(r_alloc_idx), .alloc_gnt(r_alloc_gnt), .free_valid(r_free_valid),
        .free_idx(r_free_idx), .flush(r_flush), .used_map(r_used_map), .used_cnt(r_used_cnt),
        .full(r_full), .empty(r_empty), .free_err(r_free_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req = 0; free_valid = 0; flush = 0; free_idx = 0;
        r_alloc_req = 0; r_free_valid = 0; r_flush = 0; r_free_idx = 0;
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #2 resetn = 0;
        #4 resetn = 1;
        tick();
    endtask

    task automatic fill_all();
        alloc_req = 1;
        repeat (32) tick();
        alloc_req = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        idle();
        #12 resetn = 1;
        tick();
        checks++; if (used_map !== 32'h0) begin errors++;
            $display("FAIL reset_used_map got %h want %h", used_map, 32'h0); end
        checks++; if ({alloc_valid, alloc_idx, used_cnt, full, empty, free_err} !==
                      {1'b1, 5'd0, 6'd0, 1'b0, 1'b1, 1'b0}) begin errors++;
            $display("FAIL reset_flags got v=%b idx=%0d cnt=%0d f=%b e=%b err=%b want 1 0 0 0 1 0",
                     alloc_valid, alloc_idx, used_cnt, full, empty, free_err); end
        checks++; if ({r_used_map, r_used_cnt, r_alloc_idx, r_alloc_valid, r_empty} !==
                      {32'h1, 6'd1, 5'd1, 1'b1, 1'b1}) begin errors++;
            $display("FAIL reset_rsv got map=%h cnt=%0d idx=%0d v=%b e=%b want 1 1 1 1 1",
                     r_used_map, r_used_cnt, r_alloc_idx, r_alloc_valid, r_empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            alloc_req = 1;
            #1;
            checks++; if ({alloc_gnt, alloc_idx} !== {1'b1, 5'(i)}) begin errors++;
                $display("FAIL fill_grant[%0d] got gnt=%b idx=%0d want gnt=1 idx=%0d",
                         i, alloc_gnt, alloc_idx, i); end
            tick();
        end
        #1;
        checks++; if ({full, alloc_valid, used_cnt, alloc_gnt} !== {1'b1, 1'b0, 6'd32, 1'b0})
        begin errors++;
            $display("FAIL fill_full got full=%b v=%b cnt=%0d gnt=%b want 1 0 32 0",
                     full, alloc_valid, used_cnt, alloc_gnt); end
        alloc_req = 0;
    endtask

    task automatic test_free_when_full();
        free_valid = 1; free_idx = 5'd17;
        tick();
        free_valid = 0;
        checks++; if ({alloc_valid, alloc_idx, used_cnt, full} !== {1'b1, 5'd17, 6'd31, 1'b0})
        begin errors++;
            $display("FAIL full_free got v=%b idx=%0d cnt=%0d full=%b want 1 17 31 0",
                     alloc_valid, alloc_idx, used_cnt, full); end
        alloc_req = 1;
        #1;
        checks++; if (alloc_gnt !== 1'b1) begin errors++;
            $display("FAIL full_regrant got %b want 1", alloc_gnt); end
        tick();
        alloc_req = 0;
        checks++; if ({full, used_map} !== {1'b1, 32'hFFFF_FFFF}) begin errors++;
            $display("FAIL full_again got full=%b map=%h want 1 ffffffff", full, used_map); end
    endtask

    task automatic test_alloc_and_free();
        do_reset();
        alloc_req = 1;
        repeat (4) tick();
        checks++; if (used_map !== 32'h0000_000F) begin errors++;
            $display("FAIL af_setup got %h want 0000000f", used_map); end
        free_valid = 1; free_idx = 5'd2;
        #1;
        checks++; if ({alloc_gnt, alloc_idx} !== {1'b1, 5'd4}) begin errors++;
            $display("FAIL af_grant got gnt=%b idx=%0d want 1 4", alloc_gnt, alloc_idx); end
        tick();
        idle();
        checks++; if ({used_map, used_cnt, alloc_idx} !== {32'h0000_001B, 6'd4, 5'd2}) begin
            errors++;
            $display("FAIL af_result got map=%h cnt=%0d idx=%0d want 0000001b 4 2",
                     used_map, used_cnt, alloc_idx); end
    endtask

    task automatic test_illegal_free();
        free_valid = 1; free_idx = 5'd9;
        tick();
        free_valid = 0;
        checks++; if ({free_err, used_map} !== {1'b1, 32'h0000_001B}) begin errors++;
            $display("FAIL bad_free got err=%b map=%h want 1 0000001b", free_err, used_map); end
        repeat (2) tick();
        checks++; if (free_err !== 1'b1) begin errors++;
            $display("FAIL bad_free_sticky got %b want 1", free_err); end
        r_free_valid = 1; r_free_idx = 5'd0;
        tick();
        r_free_valid = 0;
        checks++; if ({r_free_err, r_used_map} !== {1'b1, 32'h1}) begin errors++;
            $display("FAIL rsv_free got err=%b map=%h want 1 00000001", r_free_err, r_used_map); end
        for (int i = 1; i <= 3; i++) begin
            r_alloc_req = 1;
            #1;
            checks++; if ({r_alloc_gnt, r_alloc_idx} !== {1'b1, 5'(i)}) begin errors++;
                $display("FAIL rsv_alloc[%0d] got gnt=%b idx=%0d want 1 %0d",
                         i, r_alloc_gnt, r_alloc_idx, i); end
            tick();
        end
        r_alloc_req = 0;
    endtask

    task automatic test_flush();
        do_reset();
        fill_all();
        for (int i = 8; i < 16; i++) begin
            free_valid = 1; free_idx = 5'(i);
            tick();
        end
        free_valid = 0;
        r_alloc_req = 1;
        repeat (3) tick();
        r_alloc_req = 0;
        checks++; if ({used_map, r_used_map} !== {32'hFFFF_00FF, 32'h0000_000F}) begin errors++;
            $display("FAIL flush_setup got %h %h want ffff00ff 0000000f", used_map, r_used_map);
        end
        flush = 1; alloc_req = 1; free_valid = 1; free_idx = 5'd3; r_flush = 1;
        #1;
        checks++; if (alloc_gnt !== 1'b0) begin errors++;
            $display("FAIL flush_gnt got %b want 0", alloc_gnt); end
        tick();
        idle();
        checks++; if ({used_map, empty, alloc_idx, used_cnt, free_err} !==
                      {32'h0, 1'b1, 5'd0, 6'd0, 1'b0}) begin errors++;
            $display("FAIL flush_result got map=%h e=%b idx=%0d cnt=%0d err=%b want 0 1 0 0 0",
                     used_map, empty, alloc_idx, used_cnt, free_err); end
        checks++; if ({r_used_map, r_empty, r_alloc_idx} !== {32'h1, 1'b1, 5'd1}) begin errors++;
            $display("FAIL flush_rsv got map=%h e=%b idx=%0d want 1 1 1",
                     r_used_map, r_empty, r_alloc_idx); end
    endtask

    task automatic test_reset_mid_burst();
        alloc_req = 1;
        repeat (3) tick();
        checks++; if (used_map !== 32'h7) begin errors++;
            $display("FAIL burst_setup got %h want 00000007", used_map); end
        #2 resetn = 0;
        #1;
        checks++; if ({used_map, used_cnt, alloc_idx, alloc_valid, full, empty} !==
                      {32'h0, 6'd0, 5'd0, 1'b1, 1'b0, 1'b1}) begin errors++;
            $display("FAIL async_reset got map=%h cnt=%0d idx=%0d v=%b f=%b e=%b want 0 0 0 1 0 1",
                     used_map, used_cnt, alloc_idx, alloc_valid, full, empty); end
        #2 resetn = 1;
        #1;
        checks++; if ({alloc_gnt, alloc_idx} !== {1'b1, 5'd0}) begin errors++;
            $display("FAIL post_reset_grant got gnt=%b idx=%0d want 1 0", alloc_gnt, alloc_idx); end
        tick();
        alloc_req = 0;
        checks++; if ({used_map, alloc_idx} !== {32'h1, 5'd1}) begin errors++;
            $display("FAIL post_reset_map got map=%h idx=%0d want 00000001 1", used_map, alloc_idx);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_free_when_full();
        test_alloc_and_free();
        test_illegal_free();
        test_flush();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
